// File: rtl/raycast_pkg.sv
// Shared raycaster constants: screen geometry, texture codes, fill colours and
// the column-requester state encoding.
package raycast_pkg;

  localparam int SCREEN_WIDTH   = 320;
  localparam int SCREEN_HEIGHT  = 180;
  localparam int TIMEOUT_CYCLES = 64;

  localparam logic [3:0] TEX_RED_BRICK = 4'd3;
  localparam logic [3:0] TEX_STONE     = 4'd4;
  localparam logic [3:0] TEX_COOKIE    = 4'd5;

  localparam logic [15:0] CEIL_COLOR  = 16'h18C3;
  localparam logic [15:0] FLOOR_COLOR = 16'h4208;
  localparam logic [15:0] FLAT_COLOR  = 16'hF81F;
  localparam logic [15:0] ERR_COLOR   = 16'hFFE0;

  typedef enum logic [2:0] {
    REQ_IDLE,
    REQ_PIXEL,
    REQ_REQ,
    REQ_WAIT,
    REQ_DONE
  } req_state_e;

  function automatic logic is_textured(input logic [3:0] code);
    return (code == TEX_RED_BRICK) || (code == TEX_STONE) || (code == TEX_COOKIE);
  endfunction

endpackage

// File: rtl/tex_column_requester_if.sv
// Column descriptor, texture request/response and frame-buffer write signals
// of the column requester; master is the requester, slave its environment.
interface tex_column_requester_if;

  logic        col_valid_in;
  logic        col_ready_out;
  logic [8:0]  hcount_in;
  logic [15:0] wallX_in;
  logic [7:0]  lineheight_in;
  logic [9:0]  drawstart_in;
  logic [3:0]  texture_in;

  logic        valid_req_out;
  logic [15:0] wallX_out;
  logic [7:0]  lineheight_out;
  logic [9:0]  drawstart_out;
  logic [7:0]  vcount_ray_out;
  logic [3:0]  texture_out;
  logic [15:0] tex_pixel_in;
  logic        valid_tex_in;

  logic        fb_we_out;
  logic [15:0] fb_addr_out;
  logic [15:0] fb_data_out;
  logic        col_done_out;
  logic        timeout_err_out;

  modport master (
    input  col_valid_in, hcount_in, wallX_in, lineheight_in, drawstart_in, texture_in,
    input  tex_pixel_in, valid_tex_in,
    output col_ready_out, valid_req_out, wallX_out, lineheight_out, drawstart_out,
    output vcount_ray_out, texture_out, fb_we_out, fb_addr_out, fb_data_out,
    output col_done_out, timeout_err_out
  );

  modport slave (
    output col_valid_in, hcount_in, wallX_in, lineheight_in, drawstart_in, texture_in,
    output tex_pixel_in, valid_tex_in,
    input  col_ready_out, valid_req_out, wallX_out, lineheight_out, drawstart_out,
    input  vcount_ray_out, texture_out, fb_we_out, fb_addr_out, fb_data_out,
    input  col_done_out, timeout_err_out
  );

endinterface

// File: rtl/tex_req_watchdog.sv
// Counts consecutive cycles of an outstanding texture request and flags the
// cycle on which LIMIT is reached. Only instantiated with TEX_REQ_TIMEOUT_EN.
module tex_req_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // cnt is 0 in the first waiting cycle, so LIMIT-1 marks the LIMIT-th one.
  assign expired = run && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/tex_column_requester.sv
// Walks one screen column, fetching a texel per textured wall row and writing
// ceiling/wall/floor pixels to the frame buffer. TEX_REQ_TIMEOUT_EN adds a WAIT watchdog.
module tex_column_requester
  import raycast_pkg::*;
(
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  tex_column_requester_if.master bus
);

  req_state_e  state, state_nxt;
  logic [7:0]  vcount;
  logic [15:0] fb_addr;
  logic [15:0] wallx_q;
  logic [7:0]  lineheight_q;
  logic [9:0]  drawstart_q;
  logic [3:0]  texture_q;

  logic        accept, advance, fb_we, valid_req, col_ready, col_done, timeout_hit;
  logic [15:0] fb_data;
  logic [10:0] drawend;
  logic        is_ceil, is_wall, last_row;

  // 11-bit sum so drawstart + lineheight never wraps back into the screen.
  assign drawend  = {1'b0, drawstart_q} + {3'b0, lineheight_q};
  assign is_ceil  = {2'b0, vcount} < drawstart_q;
  assign is_wall  = !is_ceil && ({3'b0, vcount} < drawend);
  assign last_row = vcount == 8'(SCREEN_HEIGHT - 1);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    fb_we     = 1'b0;
    fb_data   = '0;
    valid_req = 1'b0;
    col_ready = 1'b0;
    col_done  = 1'b0;
    unique case (state)
      REQ_IDLE: begin
        col_ready = 1'b1;
        if (bus.col_valid_in) begin
          accept    = 1'b1;
          state_nxt = REQ_PIXEL;
        end
      end
      REQ_PIXEL: begin
        if (is_wall && is_textured(texture_q)) begin
          state_nxt = REQ_REQ;
        end else begin
          fb_we   = 1'b1;
          fb_data = is_ceil ? CEIL_COLOR : (is_wall ? FLAT_COLOR : FLOOR_COLOR);
          advance = 1'b1;
        end
      end
      REQ_REQ: begin
        valid_req = 1'b1;
        state_nxt = REQ_WAIT;
      end
      REQ_WAIT: begin
        // A texel arriving on the timeout cycle wins over the error colour.
        if (bus.valid_tex_in) begin
          fb_we   = 1'b1;
          fb_data = bus.tex_pixel_in;
          advance = 1'b1;
        end else if (timeout_hit) begin
          fb_we   = 1'b1;
          fb_data = ERR_COLOR;
          advance = 1'b1;
        end
      end
      REQ_DONE: begin
        col_done  = 1'b1;
        state_nxt = REQ_IDLE;
      end
      default: state_nxt = REQ_IDLE;
    endcase
    if (advance) begin
      state_nxt = last_row ? REQ_DONE : REQ_PIXEL;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n_in) begin
      state        <= REQ_IDLE;
      vcount       <= '0;
      fb_addr      <= '0;
      wallx_q      <= '0;
      lineheight_q <= '0;
      drawstart_q  <= '0;
      texture_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        vcount       <= '0;
        fb_addr      <= {7'b0, bus.hcount_in};
        wallx_q      <= bus.wallX_in;
        lineheight_q <= bus.lineheight_in;
        drawstart_q  <= bus.drawstart_in;
        texture_q    <= bus.texture_in;
      end else if (advance) begin
        // Row stride added incrementally instead of vcount*SCREEN_WIDTH.
        vcount  <= vcount + 1'b1;
        fb_addr <= fb_addr + 16'(SCREEN_WIDTH);
      end
    end
  end

`ifdef TEX_REQ_TIMEOUT_EN
  logic timeout_err;

  tex_req_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (pixel_clk_in),
    .rst_n   (rst_n_in),
    .run     (state == REQ_WAIT),
    .expired (timeout_hit)
  );

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timeout_err <= 1'b0;
    end else if ((state == REQ_WAIT) && !bus.valid_tex_in && timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end

  assign bus.timeout_err_out = timeout_err;
`else
  assign timeout_hit         = 1'b0;
  assign bus.timeout_err_out = 1'b0;
`endif

  assign bus.col_ready_out  = col_ready;
  assign bus.valid_req_out  = valid_req;
  assign bus.wallX_out      = wallx_q;
  assign bus.lineheight_out = lineheight_q;
  assign bus.drawstart_out  = drawstart_q;
  assign bus.vcount_ray_out = vcount;
  assign bus.texture_out    = texture_q;
  assign bus.fb_we_out      = fb_we;
  assign bus.fb_addr_out    = fb_addr;
  assign bus.fb_data_out    = fb_data;
  assign bus.col_done_out   = col_done;

endmodule
